// File: rtl/ex_mem_reg_pkg.sv
// Shared core constants (macro header equivalent) for the EX->MEM pipeline register.
// Holds reset/stall/write-enable encodings, bus widths and the stall-vector stage indices.
package ex_mem_reg_pkg;

    localparam int unsigned REGBUS       = 32;
    localparam int unsigned REGADDRBUS   = 5;
    localparam int unsigned DOUBLEREGBUS = 64;
    localparam int unsigned STALLBUS     = 6;

    // Stall vector bit positions: bit 0 = PC ... bit 5 = WB
    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;

    localparam logic RSTENABLE    = 1'b1;
    localparam logic STOP         = 1'b1;
    localparam logic NOSTOP       = 1'b0;
    localparam logic WRITEENABLE  = 1'b1;
    localparam logic WRITEDISABLE = 1'b0;

    localparam logic [REGBUS-1:0] ZEROWORD = '0;

    // Per-edge behaviour of the pipeline register
    typedef enum logic [1:0] {
        MODE_ADVANCE = 2'd0,
        MODE_BUBBLE  = 2'd1,
        MODE_HOLD    = 2'd2,
        MODE_CLEAR   = 2'd3
    } stage_mode_e;

endpackage

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register of the 5-stage MIPS core.
// Captures the EX result (GPR write, HI/LO write) and presents it to MEM one cycle later.
// Honours the stall vector (bubble / hold) and flush, and stores the MADD/MSUB
// intermediate (hilo_o, cnt_o) which is fed back to EX while EX is stalled.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   stall, flush         stall vector and squash request from ctrl
//   ex_*                 EX-stage result (GPR addr/we/data, HI/LO data/we)
//   hilo_i, cnt_i        MADD/MSUB partial product and cycle count from EX
//   mem_*                registered EX result towards MEM
//   hilo_o, cnt_o        stored partial product and count back to EX
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int unsigned DATA_W  = REGBUS,
    parameter int unsigned ADDR_W  = REGADDRBUS,
    parameter int unsigned STALL_W = STALLBUS,
    parameter int unsigned EX_IDX  = STALL_EX,
    parameter int unsigned MEM_IDX = STALL_MEM
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic                ex_whilo,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [1:0]          cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_whilo,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [1:0]          cnt_o
);

    logic [ADDR_W-1:0]   mem_wd_q,    mem_wd_d;
    logic                mem_wreg_q,  mem_wreg_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   mem_hi_q,    mem_hi_d;
    logic [DATA_W-1:0]   mem_lo_q,    mem_lo_d;
    logic                mem_whilo_q, mem_whilo_d;
    logic [2*DATA_W-1:0] hilo_q,      hilo_d;
    logic [1:0]          cnt_q,       cnt_d;

    stage_mode_e mode_c;

    // Only the EX and MEM stall bits matter here; the rest are intentionally ignored
    logic unused_stall_c;
    assign unused_stall_c = ^stall;

    // Mode decode: flush beats stall; EX not stalled always advances
    always_comb begin
        mode_c = MODE_ADVANCE;
        if (flush) begin
            mode_c = MODE_CLEAR;
        end else if (stall[EX_IDX] == NOSTOP) begin
            mode_c = MODE_ADVANCE;
        end else if (stall[MEM_IDX] == NOSTOP) begin
            mode_c = MODE_BUBBLE;
        end else begin
            mode_c = MODE_HOLD;
        end
    end

    // Next-state: hold by default, then apply the decoded mode
    always_comb begin
        mem_wd_d    = mem_wd_q;
        mem_wreg_d  = mem_wreg_q;
        mem_wdata_d = mem_wdata_q;
        mem_hi_d    = mem_hi_q;
        mem_lo_d    = mem_lo_q;
        mem_whilo_d = mem_whilo_q;
        hilo_d      = hilo_q;
        cnt_d       = cnt_q;
        case (mode_c)
            MODE_CLEAR: begin
                // Clearing cnt aborts any MADD/MSUB in flight
                mem_wd_d    = '0;
                mem_wreg_d  = WRITEDISABLE;
                mem_wdata_d = '0;
                mem_hi_d    = '0;
                mem_lo_d    = '0;
                mem_whilo_d = WRITEDISABLE;
                hilo_d      = '0;
                cnt_d       = 2'b00;
            end
            MODE_BUBBLE: begin
                // MEM gets a bubble while EX parks its MADD/MSUB intermediate here
                mem_wd_d    = '0;
                mem_wreg_d  = WRITEDISABLE;
                mem_wdata_d = '0;
                mem_hi_d    = '0;
                mem_lo_d    = '0;
                mem_whilo_d = WRITEDISABLE;
                hilo_d      = hilo_i;
                cnt_d       = cnt_i;
            end
            MODE_ADVANCE: begin
                mem_wd_d    = ex_wd;
                mem_wreg_d  = ex_wreg;
                mem_wdata_d = ex_wdata;
                mem_hi_d    = ex_hi;
                mem_lo_d    = ex_lo;
                mem_whilo_d = ex_whilo;
                hilo_d      = '0;
                cnt_d       = 2'b00;
            end
            default: begin
                // MODE_HOLD: keep everything
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst == RSTENABLE) begin
            mem_wd_q    <= '0;
            mem_wreg_q  <= WRITEDISABLE;
            mem_wdata_q <= '0;
            mem_hi_q    <= '0;
            mem_lo_q    <= '0;
            mem_whilo_q <= WRITEDISABLE;
            hilo_q      <= '0;
            cnt_q       <= 2'b00;
        end else begin
            mem_wd_q    <= mem_wd_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_wdata_q <= mem_wdata_d;
            mem_hi_q    <= mem_hi_d;
            mem_lo_q    <= mem_lo_d;
            mem_whilo_q <= mem_whilo_d;
            hilo_q      <= hilo_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_wd    = mem_wd_q;
    assign mem_wreg  = mem_wreg_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_hi    = mem_hi_q;
    assign mem_lo    = mem_lo_q;
    assign mem_whilo = mem_whilo_q;
    assign hilo_o    = hilo_q;
    assign cnt_o     = cnt_q;

    // ctrl never stalls MEM while letting EX run
    assert property (@(posedge clk) disable iff (rst)
        !((stall[EX_IDX] == NOSTOP) && (stall[MEM_IDX] == STOP)));

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios followed by randomized
// cycles, all compared against a behavioural model of the register's rules.
module tb_ex_mem_reg;
    import ex_mem_reg_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall;
    logic          flush;
    logic [AW-1:0] ex_wd;
    logic          ex_wreg;
    logic [DW-1:0] ex_wdata, ex_hi, ex_lo;
    logic          ex_whilo;
    logic [63:0]   hilo_i;
    logic [1:0]    cnt_i;
    logic [AW-1:0] mem_wd;
    logic          mem_wreg;
    logic [DW-1:0] mem_wdata, mem_hi, mem_lo;
    logic          mem_whilo;
    logic [63:0]   hilo_o;
    logic [1:0]    cnt_o;

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: what MEM and EX should observe after the next edge
    logic [AW-1:0] m_wd;
    logic          m_wreg, m_whilo;
    logic [DW-1:0] m_wdata, m_hi, m_lo;
    logic [63:0]   m_hilo;
    logic [1:0]    m_cnt;

    task automatic model_zero();
        m_wd = '0; m_wreg = 1'b0; m_wdata = '0; m_hi = '0; m_lo = '0;
        m_whilo = 1'b0; m_hilo = '0; m_cnt = 2'b00;
    endtask

    task automatic model_step();
        if (rst || flush) begin
            model_zero();
        end else if (!stall[3]) begin
            m_wd = ex_wd; m_wreg = ex_wreg; m_wdata = ex_wdata;
            m_hi = ex_hi; m_lo = ex_lo; m_whilo = ex_whilo;
            m_hilo = '0; m_cnt = 2'b00;
        end else if (!stall[4]) begin
            m_wd = '0; m_wreg = 1'b0; m_wdata = '0; m_hi = '0; m_lo = '0;
            m_whilo = 1'b0; m_hilo = hilo_i; m_cnt = cnt_i;
        end
        // else: both stalled, model keeps its state
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".mem_wd"},    64'(mem_wd),    64'(m_wd));
        chk({tag, ".mem_wreg"},  64'(mem_wreg),  64'(m_wreg));
        chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(m_wdata));
        chk({tag, ".mem_hi"},    64'(mem_hi),    64'(m_hi));
        chk({tag, ".mem_lo"},    64'(mem_lo),    64'(m_lo));
        chk({tag, ".mem_whilo"}, 64'(mem_whilo), 64'(m_whilo));
        chk({tag, ".hilo_o"},    hilo_o,         m_hilo);
        chk({tag, ".cnt_o"},     64'(cnt_o),     64'(m_cnt));
    endtask

    // Advance the model with the current inputs, clock once, compare after the edge
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_ex(input logic [AW-1:0] wd, input logic wreg, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] hi, input logic [DW-1:0] lo, input logic whilo);
        ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_hi = hi; ex_lo = lo; ex_whilo = whilo;
    endtask

    initial begin
        model_zero();
        rst = 1'b1; flush = 1'b0; stall = 6'b0;
        set_ex(5'd31, 1'b1, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        hilo_i = 64'hFFFF_0000_FFFF_0000; cnt_i = 2'b11;

        // 1 Reset with non-zero EX inputs
        tick("rst0");
        tick("rst1");
        chk("rst.cnt_const", 64'(cnt_o), 64'd0);

        // 2 Advance
        rst = 1'b0;
        set_ex(5'd5, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0);
        tick("adv");
        chk("adv.wdata_const", 64'(mem_wdata), 64'hDEAD_BEEF);
        chk("adv.wd_const", 64'(mem_wd), 64'd5);

        // 3 MADD two-cycle sequence
        stall = 6'b001111; cnt_i = 2'b01; hilo_i = 64'h1_0000_0002;
        tick("madd_a");
        chk("madd_a.hilo_const", hilo_o, 64'h1_0000_0002);
        chk("madd_a.cnt_const", 64'(cnt_o), 64'd1);
        stall = 6'b0; cnt_i = 2'b10; hilo_i = 64'h0;
        set_ex(5'd0, 1'b0, 32'h0, 32'd1, 32'd7, 1'b1);
        tick("madd_b");
        chk("madd_b.lo_const", 64'(mem_lo), 64'd7);
        chk("madd_b.cnt_const", 64'(cnt_o), 64'd0);

        // 4 Hold for 3 cycles while EX inputs change
        set_ex(5'd9, 1'b1, 32'h1234, 32'h0, 32'h0, 1'b0);
        tick("hold_load");
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            set_ex(AW'($urandom), 1'b1, $urandom, $urandom, $urandom, 1'b1);
            hilo_i = {$urandom, $urandom}; cnt_i = 2'($urandom);
            tick("hold");
        end
        chk("hold.wdata_const", 64'(mem_wdata), 64'h1234);

        // 5 Flush beats stall while a MADD is parked
        stall = 6'b001111; cnt_i = 2'b01; hilo_i = 64'h2_0000_0003;
        tick("fl_bub");
        stall = 6'b011111;
        tick("fl_hold");
        chk("fl_hold.cnt_const", 64'(cnt_o), 64'd1);
        flush = 1'b1;
        tick("flush");
        chk("flush.cnt_const", 64'(cnt_o), 64'd0);
        flush = 1'b0;

        // 6 Reset mid-MADD, and reset together with flush and stall
        stall = 6'b001111; cnt_i = 2'b01; hilo_i = 64'h3_0000_0004;
        tick("rm_bub");
        rst = 1'b1;
        tick("rst_mid");
        chk("rst_mid.hilo_const", hilo_o, 64'd0);
        rst = 1'b0; stall = 6'b0;
        set_ex(5'd3, 1'b1, 32'hCAFE_F00D, 32'd2, 32'd4, 1'b1);
        tick("pre_all");
        rst = 1'b1; flush = 1'b1; stall = 6'b011111;
        tick("rst_all");
        rst = 1'b0; flush = 1'b0;

        // Randomized legal traffic
        for (int i = 0; i < 400; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 9);
            if (sel < 5)      stall = {3'b000, 3'($urandom)};
            else if (sel < 8) stall = {3'b001, 3'($urandom)};
            else              stall = {1'($urandom), 2'b11, 3'($urandom)};
            flush = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 39) == 0);
            set_ex(AW'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
            hilo_i = {$urandom, $urandom}; cnt_i = 2'($urandom);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
